// File: rtl/imem_loader_responder.sv
// Instruction-memory responder for the single-cycle RISC-V CPU.
// Accepts a little-endian byte stream over a valid/ready load port, commits
// assembled 32-bit words into its array, holds the CPU in reset until the
// image is complete, then serves combinational PC->Instr fetches.
// Optional feature macro: LOADER_CHECKSUM_EN (adds a trailing check byte
// that must bring the 8-bit running sum of the image to zero).
module imem_loader_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          ADDR_W      = 8,
    parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       PC,
    output logic [31:0]       Instr,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [7:0]        ld_data,
    input  logic              ld_last,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_ERR  = 3'd3;
    localparam logic [2:0] S_CHK  = 3'd4;

    logic [2:0]  state;
    logic [1:0]  lane;
    logic [23:0] asm_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        image_byte;
    logic        full;
    logic        commit;
    logic [31:0] commit_word;
    logic        pc_unused;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  sum;
`endif

    // Handshake, status outputs and the word being committed this cycle.
    always_comb begin
        ld_ready   = (state == S_IDLE) || (state == S_LOAD) || (state == S_CHK);
        accept     = ld_valid && ld_ready;
        image_byte = accept && ((state == S_IDLE) || (state == S_LOAD));
        full       = (word_count == (ADDR_W+1)'(DEPTH_WORDS));
        commit     = image_byte && !full && ((lane == 2'd3) || ld_last);
        cpu_reset  = (state != S_RUN);
        load_done  = (state == S_RUN);
        load_err   = (state == S_ERR);
        case (lane)
            2'd0:    commit_word = {24'h000000, ld_data};
            2'd1:    commit_word = {16'h0000, ld_data, asm_q[7:0]};
            2'd2:    commit_word = {8'h00, ld_data, asm_q[15:0]};
            default: commit_word = {ld_data, asm_q[23:0]};
        endcase
    end

    // Loader state machine: lane counter, assembly register, word counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            lane       <= 2'd0;
            asm_q      <= 24'h000000;
            word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum        <= 8'h00;
`endif
        end else begin
            case (state)
                S_IDLE, S_LOAD: begin
                    if (accept) begin
                        if (full) begin
                            state <= S_ERR;
                        end else begin
                            if (commit) begin
                                word_count <= word_count + 1'b1;
                                lane       <= 2'd0;
                                asm_q      <= 24'h000000;
                            end else begin
                                asm_q <= commit_word[23:0];
                                lane  <= lane + 2'd1;
                            end
`ifdef LOADER_CHECKSUM_EN
                            sum <= sum + ld_data;
                            state <= ld_last ? S_CHK : S_LOAD;
`else
                            state <= ld_last ? S_RUN : S_LOAD;
`endif
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (accept) begin
                        state <= (8'(sum + ld_data) == 8'h00) ? S_RUN : S_ERR;
                    end
                end
`endif
                default: state <= state;
            endcase
        end
    end

    // Image array write; deliberately not reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[word_count[ADDR_W-1:0]] <= commit_word;
        end
    end

    // Combinational fetch; NOP outside RUN or outside the stored range.
    always_comb begin
        Instr     = NOP_WORD;
        pc_unused = ^PC[1:0];
        if ((state == S_RUN) && (PC[31:ADDR_W+2] == '0)) begin
            Instr = mem[PC[ADDR_W+1:2]];
        end
    end

endmodule

// File: tb/tb_imem_loader_responder.sv
// Self-checking bench for imem_loader_responder (default parameters).
// Expected words are pushed to a scoreboard while bytes are streamed and
// popped/compared through the fetch port once the CPU is released.
module tb_imem_loader_responder;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        reset;
    logic [31:0] PC;
    logic [31:0] Instr;
    logic        ld_valid;
    logic        ld_ready;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        cpu_reset;
    logic        load_done;
    logic        load_err;
    logic [8:0]  word_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          idx;
        logic [31:0] word;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_vec_t;

    exp_t       exp_q[$];
    logic [7:0] img_q[$];
    int         model_wc;

    imem_loader_responder dut (
        .clk        (clk),
        .reset      (reset),
        .PC         (PC),
        .Instr      (Instr),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        @(negedge clk);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    // Streams img_q with ld_last on the final byte, modelling word assembly
    // into the scoreboard, and checks the release timing.
    task automatic apply_stimulus(input bit gaps, input bit bad_chk);
        int          lane = 0;
        int          wc   = 0;
        logic [31:0] acc  = 32'h0;
        logic [7:0]  sum  = 8'h00;
        bit          last;
        bit          good = 1'b1;
        for (int i = 0; i < img_q.size(); i++) begin
            last = (i == img_q.size() - 1);
            if (gaps && i > 0) begin
                @(negedge clk);
                ld_valid = 1'b0;
                ld_data  = ~img_q[i];
                @(posedge clk);
                #1;
                check_output("gap_word_count", 32'(word_count), 32'(wc));
            end
            @(negedge clk);
            ld_valid = 1'b1;
            ld_data  = img_q[i];
            ld_last  = last;
            PC       = 32'h0;
            #1;
            check_output("ld_ready_loading", 32'(ld_ready), 32'd1);
            if (last) begin
                check_output("fetch_during_commit", Instr, NOP);
                check_output("load_done_before", 32'(load_done), 32'd0);
            end
            @(posedge clk);
            #1;
            ld_valid = 1'b0;
            ld_last  = 1'b0;
            acc = acc | (32'(img_q[i]) << (8 * lane));
            sum = sum + img_q[i];
            if (lane == 3 || last) begin
                exp_q.push_back('{idx: wc, word: acc});
                wc++;
                acc  = 32'h0;
                lane = 0;
            end else begin
                lane++;
            end
        end
`ifdef LOADER_CHECKSUM_EN
        check_output("chk_ld_ready", 32'(ld_ready), 32'd1);
        check_output("chk_cpu_reset", 32'(cpu_reset), 32'd1);
        good = !bad_chk;
        send_byte(bad_chk ? (8'h01 - sum) : (8'h00 - sum), 1'b1);
`endif
        if (good) begin
            check_output("load_done_after", 32'(load_done), 32'd1);
            check_output("cpu_reset_after", 32'(cpu_reset), 32'd0);
            check_output("ld_ready_run", 32'(ld_ready), 32'd0);
            check_output("load_err_run", 32'(load_err), 32'd0);
        end else begin
            check_output("chk_load_err", 32'(load_err), 32'd1);
            check_output("chk_cpu_reset_err", 32'(cpu_reset), 32'd1);
            check_output("chk_load_done_err", 32'(load_done), 32'd0);
            exp_q.delete();
        end
        check_output("word_count", 32'(word_count), 32'(wc));
        model_wc = wc;
    endtask

    // Pops every expected word and fetches it, with random PC[1:0].
    task automatic drain_scoreboard();
        exp_t e;
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            PC = 32'(e.idx) * 4 + 32'($urandom_range(0, 3));
            #1;
            check_output($sformatf("fetch_word_%0d", e.idx), Instr, e.word);
        end
    endtask

    initial begin
        fetch_vec_t tbl[6];
        logic [31:0] held;

        reset    = 1'b0;
        ld_valid = 1'b0;
        ld_data  = 8'h00;
        ld_last  = 1'b0;
        PC       = 32'h0;
        model_wc = 0;
        repeat (2) @(negedge clk);
        #1;
        check_output("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check_output("rst_load_done", 32'(load_done), 32'd0);
        check_output("rst_load_err", 32'(load_err), 32'd0);
        check_output("rst_ld_ready", 32'(ld_ready), 32'd1);
        check_output("rst_word_count", 32'(word_count), 32'd0);
        check_output("rst_instr", Instr, NOP);
        @(negedge clk);
        reset = 1'b1;

        // Two-word program and table of fetch vectors.
        tbl[0] = '{name: "pc_0",        pc: 32'h00000000, instr: 32'h00000013};
        tbl[1] = '{name: "pc_4",        pc: 32'h00000004, instr: 32'h00100093};
        tbl[2] = '{name: "pc_6",        pc: 32'h00000006, instr: 32'h00100093};
        tbl[3] = '{name: "pc_range_end", pc: 32'h00000400, instr: NOP};
        tbl[4] = '{name: "pc_1000",     pc: 32'h00001000, instr: NOP};
        tbl[5] = '{name: "pc_top",      pc: 32'hFFFFFFFC, instr: NOP};
        img_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        apply_stimulus(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            PC = tbl[i].pc;
            #1;
            check_output(tbl[i].name, Instr, tbl[i].instr);
        end
        drain_scoreboard();

        // RUN ignores further load traffic.
        PC = 32'h4;
        #1;
        held = Instr;
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b1);
        check_output("run_ignores_wc", 32'(word_count), 32'd2);
        check_output("run_ignores_instr", Instr, held);
        check_output("run_still_done", 32'(load_done), 32'd1);

        // Partial final word.
        do_reset();
        img_q = '{8'hAA, 8'hBB, 8'hCC};
        apply_stimulus(1'b0, 1'b0);
        PC = 32'h3;
        #1;
        check_output("partial_pc3", Instr, 32'h00CCBBAA);
        drain_scoreboard();

        // Idle cycles between bytes.
        do_reset();
        img_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        apply_stimulus(1'b1, 1'b0);
        PC = 32'h0;
        #1;
        check_output("gaps_word", Instr, 32'hDEADBEEF);
        drain_scoreboard();

        // Single-byte image.
        do_reset();
        img_q = '{8'h5A};
        apply_stimulus(1'b0, 1'b0);
        drain_scoreboard();

        // Reset in the middle of a load restarts at word 0.
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(8'(8'hA0 + i), 1'b0);
        check_output("midload_wc", 32'(word_count), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("async_rst_wc", 32'(word_count), 32'd0);
        check_output("async_rst_ready", 32'(ld_ready), 32'd1);
        check_output("async_rst_cpu", 32'(cpu_reset), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        img_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        apply_stimulus(1'b0, 1'b0);
        drain_scoreboard();
        PC = 32'h00001000;
        #1;
        check_output("midload_out_of_range", Instr, NOP);

        // Overflow: a byte beyond a full array goes to the error state.
        do_reset();
        for (int i = 0; i < 1024; i++) send_byte(8'($urandom), 1'b0);
        check_output("full_wc", 32'(word_count), 32'd256);
        check_output("full_ld_ready", 32'(ld_ready), 32'd1);
        check_output("full_load_err", 32'(load_err), 32'd0);
        send_byte(8'h77, 1'b0);
        PC = 32'h0;
        #1;
        check_output("ovf_load_err", 32'(load_err), 32'd1);
        check_output("ovf_cpu_reset", 32'(cpu_reset), 32'd1);
        check_output("ovf_ld_ready", 32'(ld_ready), 32'd0);
        check_output("ovf_load_done", 32'(load_done), 32'd0);
        check_output("ovf_wc", 32'(word_count), 32'd256);
        check_output("ovf_instr", Instr, NOP);
        send_byte(8'h12, 1'b1);
        check_output("ovf_sticky", 32'(load_err), 32'd1);

`ifdef LOADER_CHECKSUM_EN
        // Sum 01+02+03+04 = 0x0A, so 0xF6 closes it and 0xF7 does not.
        do_reset();
        img_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        apply_stimulus(1'b0, 1'b0);
        drain_scoreboard();
        do_reset();
        img_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        apply_stimulus(1'b0, 1'b1);
        PC = 32'h0;
        #1;
        check_output("chk_bad_instr", Instr, NOP);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
